// File: rtl/fwd_sel_unit_pkg.sv
// Shared definitions for the forwarding/hazard controller.
//   - REG_AW / SEL_W      : register-address and select-code widths
//   - SEL_* constants     : operand selector codes (4:1 mux in front of the ALU)
//   - slot_t              : one shadow-pipeline entry (EX, MEM or WB)
//   - slot_hit()          : true when a slot produces the given source register
package fwd_sel_unit_pkg;

  localparam int REG_AW = 5;
  localparam int SEL_W  = 2;

  localparam logic [SEL_W-1:0] SEL_RF     = 2'b00; // register file
  localparam logic [SEL_W-1:0] SEL_EXMEM  = 2'b01; // producer one ahead
  localparam logic [SEL_W-1:0] SEL_MEMWB  = 2'b10; // producer two ahead
  localparam logic [SEL_W-1:0] SEL_WBHOLD = 2'b11; // producer three ahead (RF not write-through)

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] wr_addr;
    logic              reg_write;
    logic              mem_read;
  } slot_t;

  // $0 is hardwired, so a write to it never forwards.
  function automatic logic slot_hit(slot_t s, logic [REG_AW-1:0] src);
    return s.valid && s.reg_write && (s.wr_addr == src) && (src != '0);
  endfunction

endpackage

// File: rtl/fwd_sel_unit_fwd_match.sv
// Per-operand forwarding select.
//   src_i  : source register address read in ID
//   use_i  : instruction actually reads src_i
//   ex_i/mem_i/wb_i : shadow slots, youngest first
//   sel_o  : select code, nearest producer wins, RF when unused or no producer
module fwd_match
  import fwd_sel_unit_pkg::*;
(
  input  logic [REG_AW-1:0] src_i,
  input  logic              use_i,
  input  slot_t             ex_i,
  input  slot_t             mem_i,
  input  slot_t             wb_i,
  output logic [SEL_W-1:0]  sel_o
);

  always_comb begin
    sel_o = SEL_RF;
    if (use_i) begin
      if      (slot_hit(ex_i,  src_i)) sel_o = SEL_EXMEM;
      else if (slot_hit(mem_i, src_i)) sel_o = SEL_MEMWB;
      else if (slot_hit(wb_i,  src_i)) sel_o = SEL_WBHOLD;
    end
  end

endmodule

// File: rtl/fwd_sel_unit.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Keeps a shadow EX/MEM/WB pipeline of destination info and produces
// registered operand-select codes aligned with the instruction's EX cycle.
//   clk, reset        : clock, async active-high reset
//   id_*              : instruction currently in ID
//   flush             : squash the ID instruction
//   stall             : combinational load-use stall (freeze PC and IF/ID)
//   ex_sel_a/ex_sel_b : registered operand selects for EX
//   ex_valid          : EX holds a real instruction
module fwd_sel_unit #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  ex_sel_a,
  output logic [SEL_W-1:0]  ex_sel_b,
  output logic              ex_valid
);
  import fwd_sel_unit_pkg::*;

  localparam int NUM_OPS = 2; // operand A (rs), operand B (rt)

  slot_t ex_q, mem_q, wb_q;
  slot_t ex_d, id_slot;

  logic [NUM_OPS-1:0][REG_AW-1:0] src;
  logic [NUM_OPS-1:0]             use_src;
  logic [NUM_OPS-1:0][SEL_W-1:0]  sel_d, sel_q;

  logic ld_hit, accept;

  assign src     = {id_rt, id_rs};
  assign use_src = {id_use_rt, id_use_rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    fwd_match u_match (
      .src_i (src[g]),
      .use_i (use_src[g]),
      .ex_i  (ex_q),
      .mem_i (mem_q),
      .wb_i  (wb_q),
      .sel_o (sel_d[g])
    );
  end

  // A load in EX has no data until MEM, so a dependent ID instruction must
  // wait one cycle; afterwards the load sits in MEM and forwards via MEM/WB.
  assign ld_hit = ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.wr_addr != '0) &&
                  (((ex_q.wr_addr == id_rs) && id_use_rs) ||
                   ((ex_q.wr_addr == id_rt) && id_use_rt));

  // flush beats stall: a squashed instruction has no hazard to wait for.
  assign stall  = id_valid && !flush && ld_hit;
  assign accept = id_valid && !flush && !ld_hit;

  assign id_slot = '{valid: 1'b1, wr_addr: id_wr_addr,
                     reg_write: id_reg_write, mem_read: id_mem_read};
  assign ex_d    = accept ? id_slot : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      sel_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
      sel_q <= accept ? sel_d : '0;
    end
  end

  assign ex_sel_a = sel_q[0];
  assign ex_sel_b = sel_q[1];
  assign ex_valid = ex_q.valid;

endmodule

// File: tb/tb_fwd_sel_unit.sv
module tb_fwd_sel_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, flush;
  logic [4:0] id_rs, id_rt, id_wr_addr;
  logic       stall, ex_valid;
  logic [1:0] ex_sel_a, ex_sel_b;

  int checks = 0;
  int errors = 0;

  fwd_sel_unit dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_wr_addr(id_wr_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .stall(stall),
    .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b), .ex_valid(ex_valid)
  );

  always #5 clk = ~clk;

  // Reference: history of what entered EX, index 0 = most recent (distance 1).
  typedef struct { bit v; bit [4:0] wa; bit rw; bit mr; } ent_t;
  ent_t hist [3];
  logic [1:0] exp_a, exp_b;
  logic       exp_v;

  function automatic logic [1:0] m_sel(logic [4:0] s, logic u);
    if (!u || s == 5'd0) return 2'd0;
    for (int d = 0; d < 3; d++)
      if (hist[d].v && hist[d].rw && hist[d].wa == s) return 2'(d + 1);
    return 2'd0;
  endfunction

  function automatic logic m_stall();
    ent_t e = hist[0];
    if (!id_valid || flush || reset) return 1'b0;
    if (!(e.v && e.mr && e.rw && e.wa != 5'd0)) return 1'b0;
    return (e.wa == id_rs && id_use_rs) || (e.wa == id_rt && id_use_rt);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 3; i++) hist[i] = '{0, 5'd0, 0, 0};
    exp_a = 2'd0; exp_b = 2'd0; exp_v = 1'b0;
  endtask

  task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic [4:0] wa,
                     input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wr_addr = wa; id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  // Advance one clock; the model follows the same edge.
  task automatic tick();
    ent_t  n;
    logic  acc;
    acc   = id_valid && !flush && !m_stall() && !reset;
    n     = acc ? '{1, id_wr_addr, id_reg_write, id_mem_read} : '{0, 5'd0, 0, 0};
    exp_a = acc ? m_sel(id_rs, id_use_rs) : 2'd0;
    exp_b = acc ? m_sel(id_rt, id_use_rt) : 2'd0;
    exp_v = acc;
    @(posedge clk);
    if (reset) m_clear();
    else begin
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = n;
    end
    #1;
  endtask

  task automatic nop();  drv(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic drain(); nop(); repeat (3) tick(); endtask

  task automatic test_reset();
    reset = 1'b1;
    drv(1, 5'd3, 5'd3, 1, 1, 5'd3, 1, 1, 0);
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    checks += 4;
    if (stall !== 1'b0)    begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ex_valid); end
    if (ex_sel_a !== 2'd0) begin errors++; $display("FAIL reset_sel_a got %0d want 0", ex_sel_a); end
    if (ex_sel_b !== 2'd0) begin errors++; $display("FAIL reset_sel_b got %0d want 0", ex_sel_b); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    nop();
  endtask

  task automatic test_back_to_back();
    drain();
    drv(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();   // add $3,$1,$2
    drv(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0); #1;       // sub $4,$3,$5
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b want 0", stall); end
    tick();
    checks += 3;
    if (ex_sel_a !== 2'b01) begin errors++; $display("FAIL b2b_sel_a got %b want 01", ex_sel_a); end
    if (ex_sel_b !== 2'b00) begin errors++; $display("FAIL b2b_sel_b got %b want 00", ex_sel_b); end
    if (ex_valid !== 1'b1)  begin errors++; $display("FAIL b2b_valid got %b want 1", ex_valid); end
  endtask

  task automatic test_distance();
    logic [1:0] want;
    for (int gap = 1; gap <= 3; gap++) begin
      drain();
      drv(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();  // add $3
      nop(); repeat (gap) tick();
      drv(1, 5'd3, 5'd3, 1, 1, 5'd6, 1, 0, 0); tick();  // or $6,$3,$3
      want = (gap == 3) ? 2'b00 : 2'(gap + 1);
      checks += 2;
      if (ex_sel_a !== want) begin errors++; $display("FAIL dist%0d_sel_a got %b want %b", gap + 1, ex_sel_a, want); end
      if (ex_sel_b !== want) begin errors++; $display("FAIL dist%0d_sel_b got %b want %b", gap + 1, ex_sel_b, want); end
    end
  endtask

  task automatic test_load_use();
    drain();
    drv(1, 5'd2, 5'd0, 1, 0, 5'd8, 1, 1, 0); tick();   // lw $8
    drv(1, 5'd8, 5'd1, 1, 1, 5'd9, 1, 0, 0); #1;       // add $9,$8,$1
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", stall); end
    tick();
    checks += 3;
    if (ex_valid !== 1'b0)  begin errors++; $display("FAIL lu_bubble_valid got %b want 0", ex_valid); end
    if (ex_sel_a !== 2'b00) begin errors++; $display("FAIL lu_bubble_sel got %b want 00", ex_sel_a); end
    if (stall !== 1'b0)     begin errors++; $display("FAIL lu_stall_drop got %b want 0", stall); end
    tick();
    checks += 3;
    if (ex_sel_a !== 2'b10) begin errors++; $display("FAIL lu_sel_a got %b want 10", ex_sel_a); end
    if (ex_sel_b !== 2'b00) begin errors++; $display("FAIL lu_sel_b got %b want 00", ex_sel_b); end
    if (ex_valid !== 1'b1)  begin errors++; $display("FAIL lu_valid got %b want 1", ex_valid); end
  endtask

  task automatic test_zero_reg();
    drain();
    drv(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0); tick();   // lw $0
    drv(1, 5'd0, 5'd0, 1, 1, 5'd5, 1, 0, 0); #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got %b want 0", stall); end
    tick();
    checks += 2;
    if (ex_sel_a !== 2'b00) begin errors++; $display("FAIL zero_sel_a got %b want 00", ex_sel_a); end
    if (ex_sel_b !== 2'b00) begin errors++; $display("FAIL zero_sel_b got %b want 00", ex_sel_b); end
  endtask

  task automatic test_flush_nearest();
    drain();
    drv(1, 5'd2, 5'd0, 1, 0, 5'd8, 1, 1, 0); tick();   // lw $8
    drv(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 1); #1;       // dependent, flushed
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", stall); end
    tick();
    checks += 3;
    if (ex_valid !== 1'b0)  begin errors++; $display("FAIL flush_valid got %b want 0", ex_valid); end
    if (ex_sel_a !== 2'b00) begin errors++; $display("FAIL flush_sel_a got %b want 00", ex_sel_a); end
    if (ex_sel_b !== 2'b00) begin errors++; $display("FAIL flush_sel_b got %b want 00", ex_sel_b); end
    drain();
    drv(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0); tick();   // add $3 (two ahead)
    drv(1, 5'd4, 5'd5, 1, 1, 5'd3, 1, 0, 0); tick();   // add $3 (one ahead)
    drv(1, 5'd3, 5'd3, 1, 1, 5'd7, 1, 0, 0); tick();   // rs==rt==$3
    checks += 2;
    if (ex_sel_a !== 2'b01) begin errors++; $display("FAIL nearest_sel_a got %b want 01", ex_sel_a); end
    if (ex_sel_b !== 2'b01) begin errors++; $display("FAIL nearest_sel_b got %b want 01", ex_sel_b); end
  endtask

  task automatic test_async_reset();
    drain();
    drv(1, 5'd2, 5'd0, 1, 0, 5'd8, 1, 1, 0); tick();   // lw $8
    drv(1, 5'd8, 5'd0, 1, 0, 5'd9, 1, 0, 0); #1;
    checks += 2;
    if (stall !== 1'b1)    begin errors++; $display("FAIL ares_pre_stall got %b want 1", stall); end
    if (ex_valid !== 1'b1) begin errors++; $display("FAIL ares_pre_valid got %b want 1", ex_valid); end
    #1 reset = 1'b1;
    #1;
    m_clear();
    checks += 4;
    if (stall !== 1'b0)    begin errors++; $display("FAIL ares_stall got %b want 0", stall); end
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL ares_valid got %b want 0", ex_valid); end
    if (ex_sel_a !== 2'd0) begin errors++; $display("FAIL ares_sel_a got %b want 00", ex_sel_a); end
    if (ex_sel_b !== 2'd0) begin errors++; $display("FAIL ares_sel_b got %b want 00", ex_sel_b); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    drv(1, 5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0); #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL ares_post_stall got %b want 0", stall); end
    tick();
    checks += 2;
    if (ex_sel_a !== 2'b00) begin errors++; $display("FAIL ares_post_sel_a got %b want 00", ex_sel_a); end
    if (ex_sel_b !== 2'b00) begin errors++; $display("FAIL ares_post_sel_b got %b want 00", ex_sel_b); end
  endtask

  task automatic test_random();
    logic held = 1'b0;
    logic ms;
    for (int it = 0; it < 400; it++) begin
      // A stalled instruction stays in ID; otherwise draw a new one.
      if (!held)
        drv($urandom_range(7) != 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
            1'($urandom), 1'($urandom), 5'($urandom_range(3)),
            1'($urandom), 1'($urandom_range(2) == 0), $urandom_range(7) == 0);
      else
        flush = ($urandom_range(7) == 0);
      #1;
      ms = m_stall();
      checks++;
      if (stall !== ms) begin errors++; $display("FAIL rnd_stall it=%0d got %b want %b", it, stall, ms); end
      held = ms;
      tick();
      checks += 3;
      if (ex_sel_a !== exp_a) begin errors++; $display("FAIL rnd_sel_a it=%0d got %b want %b", it, ex_sel_a, exp_a); end
      if (ex_sel_b !== exp_b) begin errors++; $display("FAIL rnd_sel_b it=%0d got %b want %b", it, ex_sel_b, exp_b); end
      if (ex_valid !== exp_v) begin errors++; $display("FAIL rnd_valid it=%0d got %b want %b", it, ex_valid, exp_v); end
    end
  endtask

  initial begin
    nop();
    m_clear();
    test_reset();
    test_back_to_back();
    test_distance();
    test_load_use();
    test_zero_reg();
    test_flush_nearest();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
